// File: rtl/tmr_irq_ctrl.sv
// Interrupt controller for the 8-bit timer's TMR_OVF / TMR_UDF flags: edge detect, sticky
// status, saturating event counters, one maskable irq, APB slave. Optional macro TMR_IRQ_SYNC_EN.
module tmr_irq_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  tmr_ovf,
  input  logic                  tmr_udf,
  output logic                  irq
);

  typedef enum logic [1:0] {
    REG_IER     = 2'd0,
    REG_ISR     = 2'd1,
    REG_OVF_CNT = 2'd2,
    REG_UDF_CNT = 2'd3
  } reg_addr_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           ier_q, ier_d;
  logic [1:0]           isr_q, isr_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_WIDTH-1:0] udf_cnt_q, udf_cnt_d;
  logic                 ovf_hist_q, udf_hist_q;
  logic                 ovf_in, udf_in;
  logic                 ovf_evt, udf_evt;
  logic                 access, addr_ok, wr_en;
  reg_addr_e            reg_sel;

`ifdef TMR_IRQ_SYNC_EN
  // Two-flop synchronizers for flags coming from an unrelated timer clock domain.
  logic [1:0] ovf_sync_q, ovf_sync_d;
  logic [1:0] udf_sync_q, udf_sync_d;

  assign ovf_sync_d = {ovf_sync_q[0], tmr_ovf};
  assign udf_sync_d = {udf_sync_q[0], tmr_udf};
  assign ovf_in     = ovf_sync_q[1];
  assign udf_in     = udf_sync_q[1];

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ovf_sync_q <= '0;
      udf_sync_q <= '0;
    end else begin
      ovf_sync_q <= ovf_sync_d;
      udf_sync_q <= udf_sync_d;
    end
  end
`else
  assign ovf_in = tmr_ovf;
  assign udf_in = tmr_udf;
`endif

  assign ovf_evt = ovf_in & ~ovf_hist_q;
  assign udf_evt = udf_in & ~udf_hist_q;

  assign access  = psel & penable;
  assign addr_ok = (32'(paddr) < 32'd4);
  assign wr_en   = access & pwrite & addr_ok;
  assign reg_sel = reg_addr_e'(paddr[1:0]);

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    ier_d     = ier_q;
    isr_d     = isr_q;
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;

    if (wr_en) begin
      case (reg_sel)
        REG_IER:     ier_d     = pwdata[1:0];
        REG_ISR:     isr_d     = isr_q & ~pwdata[1:0];
        REG_OVF_CNT: ovf_cnt_d = '0;
        REG_UDF_CNT: udf_cnt_d = '0;
        default:     ;
      endcase
    end

    // Events are applied after the write so a coincident set or increment wins over a clear.
    isr_d = isr_d | {udf_evt, ovf_evt};
    if (ovf_evt && ovf_cnt_d != CNT_MAX) ovf_cnt_d = ovf_cnt_d + 1'b1;
    if (udf_evt && udf_cnt_d != CNT_MAX) udf_cnt_d = udf_cnt_d + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ier_q      <= '0;
      isr_q      <= '0;
      ovf_cnt_q  <= '0;
      udf_cnt_q  <= '0;
      ovf_hist_q <= 1'b0;
      udf_hist_q <= 1'b0;
    end else begin
      ier_q      <= ier_d;
      isr_q      <= isr_d;
      ovf_cnt_q  <= ovf_cnt_d;
      udf_cnt_q  <= udf_cnt_d;
      ovf_hist_q <= ovf_in;
      udf_hist_q <= udf_in;
    end
  end

  assign irq = |(isr_q & ier_q);

  // Bus outputs are gated by reset so an in-flight access reads as idle while reset is held.
  always_comb begin
    prdata = '0;
    if (preset_n && access && !pwrite && addr_ok) begin
      case (reg_sel)
        REG_IER:     prdata[1:0]           = ier_q;
        REG_ISR:     prdata[1:0]           = isr_q;
        REG_OVF_CNT: prdata[CNT_WIDTH-1:0] = ovf_cnt_q;
        REG_UDF_CNT: prdata[CNT_WIDTH-1:0] = udf_cnt_q;
        default:     ;
      endcase
    end
  end

  assign pready  = preset_n & access;
  assign pslverr = preset_n & access & ~addr_ok;

  logic unused_pwdata;
  assign unused_pwdata = ^pwdata[DATA_WIDTH-1:2];

endmodule

// File: tb/tb_tmr_irq_ctrl.sv
// Directed bench for tmr_irq_ctrl: table of APB register vectors plus hand-written
// sequences for edge detection, saturation, coincident clear/set and mid-transfer reset.
module tb_tmr_irq_ctrl;

`ifdef TMR_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       pclk = 1'b0;
  logic       preset_n = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0] paddr = '0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic       tmr_ovf = 1'b0, tmr_udf = 1'b0;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  tmr_irq_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tmr_ovf(tmr_ovf), .tmr_udf(tmr_udf), .irq(irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Full APB transfer; called 1 unit after an edge, returns 1 unit after the commit edge.
  task automatic apb(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    #1 check("pready_setup", pready, 1'b0);
    tick(1);
    penable = 1'b1;
    #1;
    check("pready_access", pready, 1'b1);
    rd  = prdata;
    err = pslverr;
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] addr, input logic [7:0] exp);
    logic [7:0] rd;
    logic       err;
    apb(1'b0, addr, 8'h00, rd, err);
    check(name, rd, exp);
    check({name, "_err"}, err, 1'b0);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] wd);
    logic [7:0] rd;
    logic       err;
    apb(1'b1, addr, wd, rd, err);
  endtask

  // Write whose commit edge is the same edge that sees a new rising edge on the chosen flag.
  task automatic wr_with_evt(input logic [2:0] addr, input logic [7:0] wd, input logic use_udf);
    if (LAT == 1) begin
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd;
      tick(1);
      penable = 1'b1;
      if (use_udf) tmr_udf = 1'b1; else tmr_ovf = 1'b1;
      tick(1);
    end else begin
      if (use_udf) tmr_udf = 1'b1; else tmr_ovf = 1'b1;
      tick(LAT - 2);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd;
      tick(1);
      penable = 1'b1;
      tick(1);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tmr_ovf = 1'b0; tmr_udf = 1'b0;
    tick(LAT + 2);
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;

    vecs[0]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 3'd1, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 3'd2, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 3'd3, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 8'hFF, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 8'h03, 1'b0};
    vecs[6]  = '{1'b1, 3'd0, 8'h02, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 8'h02, 1'b0};
    vecs[8]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 3'd4, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 3'd7, 8'hFF, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0};

    #2 check("irq_in_reset", irq, 1'b0);
    check("pready_in_reset", pready, 1'b0);
    tick(2);
    preset_n = 1'b1;
    tick(1);

    // Register map basics after reset.
    foreach (vecs[i]) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end
    check("irq_idle", irq, 1'b0);

    // Held ovf flag: one event, irq after LAT edges, then W1C.
    wr(3'd0, 8'h01);
    tmr_ovf = 1'b1;
    tick(LAT - 1);
    check("irq_before_evt", irq, 1'b0);
    tick(1);
    check("irq_after_evt", irq, 1'b1);
    tick(5 - LAT);
    tmr_ovf = 1'b0;
    tick(LAT + 2);
    rd_chk("isr_ovf", 3'd1, 8'h01);
    rd_chk("ovf_cnt_held", 3'd2, 8'h01);
    wr(3'd1, 8'h01);
    rd_chk("isr_cleared", 3'd1, 8'h00);
    check("irq_cleared", irq, 1'b0);

    // Masked udf pulses, then late enable raises irq.
    wr(3'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tmr_udf = 1'b1;
      tick(1);
      tmr_udf = 1'b0;
      tick(2);
    end
    tick(LAT + 1);
    rd_chk("isr_udf", 3'd1, 8'h02);
    rd_chk("udf_cnt3", 3'd3, 8'h03);
    check("irq_masked", irq, 1'b0);
    wr(3'd0, 8'h02);
    check("irq_late_enable", irq, 1'b1);

    // Saturation, then clear coincident with a new event.
    for (int i = 0; i < 300; i++) begin
      tmr_ovf = 1'b1;
      tick(1);
      tmr_ovf = 1'b0;
      tick(1);
    end
    tick(LAT + 1);
    rd_chk("ovf_cnt_sat", 3'd2, 8'hFF);
    wr_with_evt(3'd2, 8'h00, 1'b0);
    rd_chk("ovf_cnt_clr_evt", 3'd2, 8'h01);

    // Counter clear without an event.
    wr(3'd3, 8'h5A);
    rd_chk("udf_cnt_clr", 3'd3, 8'h00);

    // W1C coincident with a new ovf event: set wins.
    wr(3'd0, 8'h01);
    wr(3'd1, 8'h02);
    check("irq_pre_w1c", irq, 1'b1);
    wr_with_evt(3'd1, 8'h01, 1'b0);
    rd_chk("isr_set_wins", 3'd1, 8'h01);
    check("irq_set_wins", irq, 1'b1);

    // Simultaneous ovf and udf events.
    wr(3'd2, 8'h00);
    tmr_ovf = 1'b1; tmr_udf = 1'b1;
    tick(1);
    tmr_ovf = 1'b0; tmr_udf = 1'b0;
    tick(LAT + 2);
    rd_chk("isr_both", 3'd1, 8'h03);
    rd_chk("ovf_cnt_both", 3'd2, 8'h01);
    rd_chk("udf_cnt_both", 3'd3, 8'h01);

    // Unmapped address: error, zero data, nothing changes.
    wr(3'd0, 8'h03);
    apb(1'b0, 3'd5, 8'h00, rd, err);
    check("rd5_err", err, 1'b1);
    check("rd5_data", rd, 8'h00);
    apb(1'b1, 3'd5, 8'hFF, rd, err);
    check("wr5_err", err, 1'b1);
    apb(1'b1, 3'd6, 8'hFF, rd, err);
    rd_chk("ier_after_bad", 3'd0, 8'h03);
    rd_chk("isr_after_bad", 3'd1, 8'h03);
    rd_chk("ovf_after_bad", 3'd2, 8'h01);
    rd_chk("udf_after_bad", 3'd3, 8'h01);

    // Reset asserted during an access phase.
    check("irq_pre_reset", irq, 1'b1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h03;
    tick(1);
    penable = 1'b1;
    #2 preset_n = 1'b0;
    #1;
    check("irq_mid_reset", irq, 1'b0);
    check("pready_mid_reset", pready, 1'b0);
    check("pslverr_mid_reset", pslverr, 1'b0);
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick(1);
    preset_n = 1'b1;
    tick(1);
    rd_chk("ier_post_reset", 3'd0, 8'h00);
    rd_chk("isr_post_reset", 3'd1, 8'h00);
    rd_chk("ovf_post_reset", 3'd2, 8'h00);
    rd_chk("udf_post_reset", 3'd3, 8'h00);
    check("irq_post_reset", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
